// File: rtl/pipe_pkg.sv
// Shared definitions for the LoongArch pipeline: bus widths, bus layouts
// and the bit positions of the load-op and exception-op fields.
package pipe_pkg;

   localparam int ES_BUS_W  = 178;
   localparam int MS_BUS_W  = 172;
   localparam int FWD_BUS_W = 39;

   // ld_op = {ld_b, ld_bu, ld_h, ld_hu, ld_w}
   localparam int LD_W  = 0;
   localparam int LD_HU = 1;
   localparam int LD_H  = 2;
   localparam int LD_BU = 3;
   localparam int LD_B  = 4;

   // exc_op bit positions (bit 0 flags a misaligned access)
   localparam int EXC_ALE = 0;
   localparam int EXC_W   = 4;

   // Execute-to-memory bus, MSB first
   typedef struct packed {
      logic [EXC_W-1:0] exc_op;
      logic [31:0]      rj;
      logic [31:0]      rkd;
      logic [33:0]      csr_data;
      logic [4:0]       ld_op;
      logic             res_from_mem;
      logic             gr_we;
      logic [4:0]       dest;
      logic [31:0]      result;
      logic [31:0]      pc;
   } es_bus_t;

   // Memory-to-write-back bus, MSB first
   typedef struct packed {
      logic [EXC_W-1:0] exc_op;
      logic [31:0]      rj;
      logic [31:0]      rkd;
      logic [33:0]      csr_data;
      logic             gr_we;
      logic [4:0]       dest;
      logic [31:0]      final_result;
      logic [31:0]      pc;
   } ms_bus_t;

endpackage

// File: rtl/load_align.sv
// Picks the addressed byte/halfword out of a load word and sign- or
// zero-extends it according to the one-hot load opcode.
module load_align
   import pipe_pkg::*;
(
   input  logic [4:0]  ld_op,
   input  logic [1:0]  a,
   input  logic [31:0] rdata,
   output logic [31:0] aligned_load
);

   logic [7:0]  byteSel;
   logic [15:0] halfSel;

   // Lane selection and extension; a full word is the fallback
   always_comb begin
      case (a)
         2'd0:    byteSel = rdata[7:0];
         2'd1:    byteSel = rdata[15:8];
         2'd2:    byteSel = rdata[23:16];
         default: byteSel = rdata[31:24];
      endcase
      halfSel = a[1] ? rdata[31:16] : rdata[15:0];
      aligned_load = rdata;
      if (ld_op[LD_B]) begin
         aligned_load = {{24{byteSel[7]}}, byteSel};
      end else if (ld_op[LD_BU]) begin
         aligned_load = {24'b0, byteSel};
      end else if (ld_op[LD_H]) begin
         aligned_load = {{16{halfSel[15]}}, halfSel};
      end else if (ld_op[LD_HU]) begin
         aligned_load = {16'b0, halfSel};
      end
   end

endmodule

// File: rtl/mem_stage.sv
// Memory stage of the five-stage pipeline: registers the execute bus,
// aligns synchronous SRAM load data and hands results to write-back.
// Optional macro MEM_LOAD_HOLD_EN builds the read-data hold used when
// write-back stalls a load past its single valid rdata cycle.
module mem_stage
   import pipe_pkg::*;
#(
   parameter int ES_BUS_W = pipe_pkg::ES_BUS_W,
   parameter int MS_BUS_W = pipe_pkg::MS_BUS_W
)(
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 ws_allowin,
   output logic                 ms_allowin,
   input  logic                 es_to_ms_valid,
   input  logic [ES_BUS_W-1:0]  es_to_ms_bus,
   input  logic [31:0]          data_sram_rdata,
   output logic                 ms_to_ws_valid,
   output logic [MS_BUS_W-1:0]  ms_to_ws_bus,
   output logic [FWD_BUS_W-1:0] ms_fwd_bus,
   output logic                 mem_ex,
   input  logic                 wb_ex,
   input  logic                 wb_ertn
);

   es_bus_t     msBus_q;
   logic        msValid_q;
   logic        flush;
   logic        accept;
   logic        excAny;
   logic        grWeEff;
   logic [31:0] loadWord;
   logic [31:0] alignedLoad;
   logic [31:0] finalResult;
   ms_bus_t     wsBus;

   assign flush      = wb_ex | wb_ertn;
   assign ms_allowin = !msValid_q || ws_allowin;
   assign accept     = es_to_ms_valid && ms_allowin;

   // Stage valid: flush wins over accepting a new instruction
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         msValid_q <= 1'b0;
      end else if (flush) begin
         msValid_q <= 1'b0;
      end else if (ms_allowin) begin
         msValid_q <= es_to_ms_valid;
      end
   end

   // Pipeline register for the execute bus
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         msBus_q <= '0;
      end else if (accept) begin
         msBus_q <= es_to_ms_bus;
      end
   end

`ifdef MEM_LOAD_HOLD_EN
   logic        firstCyc_q;
   logic        holdVld_q;
   logic        holdVld_d;
   logic [31:0] holdData_q;
   logic [31:0] holdData_d;
   logic        capture;
   logic        leave;

   assign capture = firstCyc_q && msValid_q && !ws_allowin && msBus_q.res_from_mem;
   assign leave   = msValid_q && ws_allowin;

   // Hold next state: keep the first-cycle rdata when the load stalls
   always_comb begin
      holdVld_d  = holdVld_q;
      holdData_d = holdData_q;
      if (flush) begin
         holdVld_d = 1'b0;
      end else if (capture) begin
         holdVld_d  = 1'b1;
         holdData_d = data_sram_rdata;
      end else if (leave) begin
         holdVld_d = 1'b0;
      end
   end

   // Hold registers and the first-cycle marker
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         firstCyc_q <= 1'b0;
         holdVld_q  <= 1'b0;
         holdData_q <= '0;
      end else begin
         firstCyc_q <= accept;
         holdVld_q  <= holdVld_d;
         holdData_q <= holdData_d;
      end
   end

   assign loadWord = holdVld_q ? holdData_q : data_sram_rdata;
`else
   assign loadWord = data_sram_rdata;
`endif

   load_align u_load_align (
      .ld_op        (msBus_q.ld_op),
      .a            (msBus_q.result[1:0]),
      .rdata        (loadWord),
      .aligned_load (alignedLoad)
   );

   assign finalResult = msBus_q.res_from_mem ? alignedLoad : msBus_q.result;
   assign excAny      = |msBus_q.exc_op;
   assign grWeEff     = msBus_q.gr_we && !excAny;

   // Assemble the write-back bus; an excepting instruction never writes a GPR
   always_comb begin
      wsBus.exc_op       = msBus_q.exc_op;
      wsBus.rj           = msBus_q.rj;
      wsBus.rkd          = msBus_q.rkd;
      wsBus.csr_data     = msBus_q.csr_data;
      wsBus.gr_we        = grWeEff;
      wsBus.dest         = msBus_q.dest;
      wsBus.final_result = finalResult;
      wsBus.pc           = msBus_q.pc;
   end

   assign ms_to_ws_bus   = wsBus;
   assign ms_to_ws_valid = msValid_q;
   assign mem_ex         = msValid_q && excAny;
   assign ms_fwd_bus     = {msValid_q, grWeEff, msBus_q.dest, finalResult};

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed load/stall/flush/reset
// cases followed by randomized traffic against a behavioural model.
// The stall/hold cases are only exercised when MEM_LOAD_HOLD_EN is defined.
module tb_mem_stage;

   typedef struct packed {
      logic [3:0]  exc;
      logic [31:0] rj;
      logic [31:0] rkd;
      logic [33:0] csr;
      logic [4:0]  ldop;
      logic        rfm;
      logic        grwe;
      logic [4:0]  dest;
      logic [31:0] result;
      logic [31:0] pc;
   } instrT;

   logic         clk;
   logic         resetn;
   logic         wsAllowin;
   logic         msAllowin;
   logic         esValid;
   logic [177:0] esBus;
   logic [31:0]  rdata;
   logic         msToWsValid;
   logic [171:0] msToWsBus;
   logic [38:0]  fwdBus;
   logic         memEx;
   logic         wbEx;
   logic         wbErtn;

   int testsRun    = 0;
   int testsFailed = 0;

   // Reference model state: the instruction in the stage and its load word
   bit          mValid = 0;
   bit          mFirst = 0;
   instrT       mInstr = '0;
   logic [31:0] mData  = '0;
   instrT       esInstr;

   mem_stage dut (
      .clk             (clk),
      .resetn          (resetn),
      .ws_allowin      (wsAllowin),
      .ms_allowin      (msAllowin),
      .es_to_ms_valid  (esValid),
      .es_to_ms_bus    (esBus),
      .data_sram_rdata (rdata),
      .ms_to_ws_valid  (msToWsValid),
      .ms_to_ws_bus    (msToWsBus),
      .ms_fwd_bus      (fwdBus),
      .mem_ex          (memEx),
      .wb_ex           (wbEx),
      .wb_ertn         (wbErtn)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts and reports
   task automatic checkOutput(input string tag, input logic [171:0] actual, input logic [171:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
      end
   endtask

   // Load value from the architectural rules, using plain shifts and masks
   function automatic logic [31:0] loadValue(input logic [4:0] ldop, input logic [1:0] a, input logic [31:0] w);
      logic [31:0] b;
      logic [31:0] h;
      b = (w >> (8 * a)) & 32'hFF;
      h = (w >> (16 * a[1])) & 32'hFFFF;
      if (ldop[4]) return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
      if (ldop[3]) return b;
      if (ldop[2]) return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
      if (ldop[1]) return h;
      return w;
   endfunction

   function automatic logic [31:0] modelFinal();
      return mInstr.rfm ? loadValue(mInstr.ldop, mInstr.result[1:0], mData) : mInstr.result;
   endfunction

   function automatic instrT mkInstr(input logic [4:0] ldop, input logic rfm, input logic grwe,
                                     input logic [3:0] exc, input logic [31:0] result, input logic [4:0] dest);
      instrT t;
      t.exc    = exc;
      t.rj     = $urandom;
      t.rkd    = $urandom;
      t.csr    = {$urandom_range(0, 3), $urandom};
      t.ldop   = ldop;
      t.rfm    = rfm;
      t.grwe   = grwe;
      t.dest   = dest;
      t.result = result;
      t.pc     = $urandom;
      return t;
   endfunction

   function automatic instrT randInstr();
      logic       rfm;
      logic [4:0] ldop;
      logic [3:0] exc;
      rfm  = $urandom_range(0, 1);
      ldop = rfm ? (5'b00001 << $urandom_range(0, 4)) : 5'b0;
      exc  = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(1, 15)) : 4'b0;
      return mkInstr(ldop, rfm, 1'($urandom_range(0, 1)), exc, $urandom, 5'($urandom_range(0, 31)));
   endfunction

   task automatic applyStimulus(input instrT ins, input bit v, input bit ws, input logic [31:0] rd, input bit ex);
      esInstr   = ins;
      esBus     = ins;
      esValid   = v;
      wsAllowin = ws;
      rdata     = rd;
      wbEx      = ex;
      wbErtn    = 1'b0;
   endtask

   // Compare all outputs with the model in the middle of the cycle
   task automatic sampleAndCheck();
      @(negedge clk);
      if (mValid && mFirst) begin
         mData  = rdata;
         mFirst = 0;
      end
      checkOutput("allowin", 172'(msAllowin), 172'(!mValid || wsAllowin));
      checkOutput("wsValid", 172'(msToWsValid), 172'(mValid));
      checkOutput("memEx", 172'(memEx), 172'(mValid && (mInstr.exc != 4'b0)));
      if (mValid) begin
         checkOutput("wsBus", msToWsBus,
                     {mInstr.exc, mInstr.rj, mInstr.rkd, mInstr.csr,
                      mInstr.grwe && (mInstr.exc == 4'b0), mInstr.dest, modelFinal(), mInstr.pc});
         checkOutput("fwdBus", 172'(fwdBus),
                     172'({1'b1, mInstr.grwe && (mInstr.exc == 4'b0), mInstr.dest, modelFinal()}));
      end else begin
         checkOutput("fwdValid", 172'(fwdBus[38]), 172'(0));
      end
   endtask

   // Clock edge: advance the model with the inputs held over the cycle
   task automatic advance();
      @(posedge clk);
      if (wbEx || wbErtn) begin
         mValid = 0;
      end else if (!mValid || wsAllowin) begin
         mValid = esValid;
         if (esValid) begin
            mInstr = esInstr;
            mFirst = 1;
         end
      end
      #1;
   endtask

   task automatic runCycle(input instrT ins, input bit v, input bit ws, input logic [31:0] rd, input bit ex);
      applyStimulus(ins, v, ws, rd, ex);
      sampleAndCheck();
      advance();
   endtask

   task automatic randomCycle();
      bit ws;
      ws = ($urandom_range(0, 9) < 7);
`ifndef MEM_LOAD_HOLD_EN
      if (mValid && mInstr.rfm) ws = 1'b1;
`endif
      applyStimulus(randInstr(), ($urandom_range(0, 9) < 7), ws, $urandom, ($urandom_range(0, 24) == 0));
      wbErtn = ($urandom_range(0, 29) == 0);
      sampleAndCheck();
      advance();
   endtask

   instrT idle;

   initial begin
      idle = '0;
      applyStimulus(idle, 1'b0, 1'b1, 32'h0, 1'b0);
      resetn = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      sampleAndCheck();
      checkOutput("rstBus", msToWsBus, 172'(0));
      checkOutput("rstFwd", 172'(fwdBus), 172'(0));
      resetn = 1'b1;
      advance();

      // Byte loads at address 0x1002
      runCycle(mkInstr(5'b01000, 1'b1, 1'b1, 4'b0, 32'h1002, 5'd3), 1'b1, 1'b1, $urandom, 1'b0);
      applyStimulus(mkInstr(5'b10000, 1'b1, 1'b1, 4'b0, 32'h1002, 5'd4), 1'b1, 1'b1, 32'h80FF_7F01, 1'b0);
      sampleAndCheck();
      checkOutput("ldbu", 172'(msToWsBus[63:32]), 172'(32'h0000_00FF));
      advance();
      applyStimulus(idle, 1'b0, 1'b1, 32'h80FF_7F01, 1'b0);
      sampleAndCheck();
      checkOutput("ldb", 172'(msToWsBus[63:32]), 172'(32'hFFFF_FFFF));
      advance();

      // Halfword loads at a=2
      runCycle(mkInstr(5'b00100, 1'b1, 1'b1, 4'b0, 32'h2002, 5'd5), 1'b1, 1'b1, $urandom, 1'b0);
      applyStimulus(mkInstr(5'b00010, 1'b1, 1'b1, 4'b0, 32'h2002, 5'd6), 1'b1, 1'b1, 32'h8001_1234, 1'b0);
      sampleAndCheck();
      checkOutput("ldh", 172'(msToWsBus[63:32]), 172'(32'hFFFF_8001));
      advance();
      applyStimulus(idle, 1'b0, 1'b1, 32'h8001_1234, 1'b0);
      sampleAndCheck();
      checkOutput("ldhu", 172'(msToWsBus[63:32]), 172'(32'h0000_8001));
      advance();

      // Plain ALU result, then an ALE exception
      runCycle(mkInstr(5'b0, 1'b0, 1'b1, 4'b0, 32'h1234, 5'd7), 1'b1, 1'b1, $urandom, 1'b0);
      applyStimulus(mkInstr(5'b0, 1'b0, 1'b1, 4'b0001, 32'h55, 5'd8), 1'b1, 1'b1, $urandom, 1'b0);
      sampleAndCheck();
      checkOutput("aluFwd", 172'(fwdBus), 172'({1'b1, 1'b1, 5'd7, 32'h1234}));
      advance();
      applyStimulus(idle, 1'b0, 1'b1, $urandom, 1'b0);
      sampleAndCheck();
      checkOutput("aleMemEx", 172'(memEx), 172'(1));
      checkOutput("aleGrWe", 172'(fwdBus[37]), 172'(0));
      advance();

`ifdef MEM_LOAD_HOLD_EN
      // Word load stalled three cycles while rdata moves on
      runCycle(mkInstr(5'b00001, 1'b1, 1'b1, 4'b0, 32'h3000, 5'd9), 1'b1, 1'b1, $urandom, 1'b0);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(idle, 1'b0, (i == 3), (i == 0) ? 32'hDEAD_BEEF : 32'h1111_1111, 1'b0);
         sampleAndCheck();
         checkOutput("holdWord", 172'(msToWsBus[63:32]), 172'(32'hDEAD_BEEF));
         advance();
      end

      // Flush a captured stalled load, then a fresh load must not see stale data
      runCycle(mkInstr(5'b00001, 1'b1, 1'b1, 4'b0, 32'h3004, 5'd10), 1'b1, 1'b1, $urandom, 1'b0);
      runCycle(idle, 1'b0, 1'b0, 32'hAAAA_AAAA, 1'b0);
      runCycle(mkInstr(5'b00001, 1'b1, 1'b1, 4'b0, 32'h3008, 5'd11), 1'b1, 1'b0, 32'h2222_2222, 1'b1);
      applyStimulus(mkInstr(5'b00001, 1'b1, 1'b1, 4'b0, 32'h300C, 5'd12), 1'b1, 1'b1, $urandom, 1'b0);
      sampleAndCheck();
      checkOutput("flushValid", 172'(msToWsValid), 172'(0));
      advance();
      applyStimulus(idle, 1'b0, 1'b0, 32'h5555_5555, 1'b0);
      sampleAndCheck();
      checkOutput("afterFlush", 172'(msToWsBus[63:32]), 172'(32'h5555_5555));
      advance();
      runCycle(idle, 1'b0, 1'b1, 32'h6666_6666, 1'b0);
`else
      // Flush in the same cycle as an accept
      runCycle(mkInstr(5'b00001, 1'b1, 1'b1, 4'b0, 32'h3004, 5'd10), 1'b1, 1'b1, $urandom, 1'b0);
      runCycle(mkInstr(5'b00001, 1'b1, 1'b1, 4'b0, 32'h3008, 5'd11), 1'b1, 1'b1, 32'hAAAA_AAAA, 1'b1);
      applyStimulus(idle, 1'b0, 1'b1, $urandom, 1'b0);
      sampleAndCheck();
      checkOutput("flushValid", 172'(msToWsValid), 172'(0));
      advance();
`endif

      // Reset asserted while an instruction is stalled
      runCycle(mkInstr(5'b0, 1'b0, 1'b1, 4'b0010, 32'h4444, 5'd13), 1'b1, 1'b1, $urandom, 1'b0);
      runCycle(idle, 1'b0, 1'b0, $urandom, 1'b0);
      applyStimulus(idle, 1'b0, 1'b0, $urandom, 1'b0);
      resetn = 1'b0;
      #1;
      checkOutput("rstValid", 172'(msToWsValid), 172'(0));
      checkOutput("rstMemEx", 172'(memEx), 172'(0));
      checkOutput("rstAllowin", 172'(msAllowin), 172'(1));
      checkOutput("rstFwdMid", 172'(fwdBus), 172'(0));
      checkOutput("rstBusMid", msToWsBus, 172'(0));
      mValid = 0;
      mFirst = 0;
      #1;
      resetn = 1'b1;
      sampleAndCheck();
      advance();

      // Randomized traffic
      for (int n = 0; n < 500; n++) begin
         randomCycle();
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
# mem_stage

Fourth stage of the five-stage LoongArch pipeline, directly downstream of the execute stage. It registers the execute-stage bus and picks up synchronous data-SRAM read data one cycle after the execute stage issued the load. It then aligns and extends load data and forwards the result plus exception state to write-back. It also exports a forwarding/hazard view for decode and a `mem_ex` flag back to execute.

## Interface
Parameters:
- `ES_BUS_W`, 178, width of incoming execute bus.
- `MS_BUS_W`, 172, width of outgoing write-back bus.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  pipeline clock.
- `resetn`  in  1  asynchronous, active-low reset.
- `ws_allowin`  in  1  write-back can accept.
- `ms_allowin`  out  1  this stage can accept.
- `es_to_ms_valid`  in  1  execute output valid.
- `es_to_ms_bus`  in  178  {exc_op[3:0], rj[31:0], rkd[31:0], csr_data[33:0], ld_op[4:0], res_from_mem, gr_we, dest[4:0], result[31:0], pc[31:0]}, MSB first.
- `data_sram_rdata`  in  32  synchronous SRAM read data.
- `ms_to_ws_valid`  out  1  output valid.
- `ms_to_ws_bus`  out  172  {exc_op[3:0], rj, rkd, csr_data, gr_we, dest, final_result, pc}.
- `ms_fwd_bus`  out  39  {ms_valid, gr_we_eff, dest[4:0], final_result[31:0]} for decode bypass.
- `mem_ex`  out  1  valid instruction here carries an exception.
- `wb_ex`, `wb_ertn`  in  1 each  flush from write-back.

## Operation
- Pipeline register `ms_bus_r` loads `es_to_ms_bus` when `es_to_ms_valid && ms_allowin`.
- `ms_valid`:
  - Cleared on reset and on `wb_ex | wb_ertn`.
  - Otherwise, when `ms_allowin`, takes `es_to_ms_valid`.
  - Flush has priority over accept.
- `ms_ready_go` = 1. `ms_allowin = !ms_valid || ws_allowin`. `ms_to_ws_valid = ms_valid`.
- Load alignment, with `a = result[1:0]`, ld_op = {ld_b, ld_bu, ld_h, ld_hu, ld_w}:
  - ld_b / ld_bu: byte `a` of rdata, sign- or zero-extended.
  - ld_h / ld_hu: halfword `a[1]`, sign- or zero-extended.
  - ld_w: whole word.
- `final_result = res_from_mem ? aligned_load : result`.
- `mem_ex = ms_valid && |exc_op`.
- `gr_we_eff = gr_we && !(|exc_op)`; an excepting instruction never writes a GPR. The `exc_op` field is passed unchanged.
- Read-data hold:
  - Flag `first_cyc` is set on accept and cleared the next cycle.
  - If `first_cyc && ms_valid && !ws_allowin && res_from_mem`, capture `data_sram_rdata` into `hold_data` and set `hold_vld`.
  - While `hold_vld`, alignment uses `hold_data`.
  - `hold_vld` clears on leave (`ms_valid && ws_allowin`) or on flush.
  - Capture and clear in the same cycle cannot occur.

## Timing
- Latency: 1 cycle, execute handoff to `ms_to_ws_valid`.
- Load data is valid only in the first `ms_valid` cycle. A later cycle uses `hold_data`, because execute keeps driving new addresses during a stall.
- Reset values:
  - `ms_valid` = 0, `first_cyc` = 0, `hold_vld` = 0, `hold_data` = 0, `ms_bus_r` = 0.
  - Hence `ms_to_ws_valid` = 0, `mem_ex` = 0, `ms_fwd_bus[38]` = 0, `ms_allowin` = 1.
- Flush in the same cycle as accept: `ms_valid` = 0 next cycle; bus contents are don't-care.
- Back-to-back loads with `ws_allowin` = 1: no hold capture; throughput 1 per cycle.
- Reset asserted mid-stall: all state returns to its reset value asynchronously.

## Configuration
- `MEM_LOAD_HOLD_EN` defined: the read-data hold logic is built.
- Undefined:
  - `hold_data`, `hold_vld` and `first_cyc` are removed; alignment always uses `data_sram_rdata`.
  - Correct only when write-back never deasserts `ws_allowin` under a valid load.
  - The test bench skips the stall scenario.

## Structure
- Package `pipe_pkg`:
  - Bus width constants `ES_BUS_W`, `MS_BUS_W`, `FWD_BUS_W`.
  - Bit-index constants for `ld_op` and `exc_op` fields.
- Sub-module `load_align`: combinational; inputs `ld_op`, `a`, `rdata`; output `aligned_load`. Used once.

## Test plan
- ld_b, `result`=0x1002, rdata=0x80FF7F01 → `final_result`=0x000000FF with ld_bu, 0xFFFFFFFF with ld_b.
- ld_h, a=2, rdata=0x8001_1234 → 0xFFFF8001; ld_hu → 0x00008001.
- ld_w, rdata 0xDEADBEEF in the first cycle; `ws_allowin`=0 for 3 cycles while rdata changes to 0x11111111 → output 0xDEADBEEF throughout and on release.
- Non-load `result`=0x1234, `gr_we`=1, `exc_op`=0 → `final_result`=0x1234, `ms_fwd_bus` = {1, 1, dest, 0x1234}.
- `exc_op`=4'b0001 (ALE), `gr_we`=1 → `mem_ex`=1, `gr_we_eff`=0.
- `wb_ex` pulse with `es_to_ms_valid`=1 the same cycle → `ms_valid`=0 next cycle and `hold_vld`=0; `resetn` low mid-stall → all outputs at reset values immediately.
